// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: widths, register index constants and basic types.
package riscv_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]       xlen_t;

  localparam reg_idx_t REG_ZERO = REG_ADDR_W'(0);
  localparam reg_idx_t REG_SP   = REG_ADDR_W'(2);
endpackage

// File: rtl/rf_read_port.sv
// One register-file read port: x0 masking plus optional write-to-read forwarding.
// Forwarding is compiled in only when REGFILE_BYPASS_EN is defined.
module rf_read_port
  import riscv_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_stored,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_wa,
  input  logic [DATA_W-1:0] i_wd,
  output logic [DATA_W-1:0] o_data
);

  logic w_is_zero;
  assign w_is_zero = (i_addr == ADDR_W'(REG_ZERO));

`ifdef REGFILE_BYPASS_EN
  logic w_hit;
  // Forward only a live write; during reset the array shows reset values.
  assign w_hit = !i_rst && i_we && (i_wa == i_addr);

  always_comb begin
    o_data = i_stored;
    if (w_hit)
      o_data = i_wd;
    if (w_is_zero)
      o_data = '0;
  end
`else
  logic w_unused;
  assign w_unused = ^{i_rst, i_we, i_wa, i_wd};

  always_comb begin
    o_data = i_stored;
    if (w_is_zero)
      o_data = '0;
  end
`endif

endmodule

// File: rtl/reg_file.sv
// RV32I architectural register file: one write port, two combinational read ports,
// a debug read port and hardwired x0. Optional forwarding via REGFILE_BYPASS_EN.
module reg_file
  import riscv_pkg::*;
#(
  parameter int                DATA_W   = XLEN,
  parameter int                ADDR_W   = REG_ADDR_W,
  parameter logic [DATA_W-1:0] SP_RESET = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int NREGS = 2 ** ADDR_W;

  // Flat read view of the array; entry 0 is the constant zero, not storage.
  logic [DATA_W-1:0] w_arr [0:NREGS-1];
  assign w_arr[0] = '0;

  for (genvar g = 1; g < NREGS; g++) begin : g_reg
    localparam logic [DATA_W-1:0] RST_VAL = (g == int'(REG_SP)) ? SP_RESET : '0;
    logic [DATA_W-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        r_q <= RST_VAL;
      else if (reg_write && (rd == ADDR_W'(g)))
        r_q <= wd;
    end

    assign w_arr[g] = r_q;
  end

  rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rp1 (
    .i_rst    (rst),
    .i_addr   (rs1),
    .i_stored (w_arr[rs1]),
    .i_we     (reg_write),
    .i_wa     (rd),
    .i_wd     (wd),
    .o_data   (rd1)
  );

  rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rp2 (
    .i_rst    (rst),
    .i_addr   (rs2),
    .i_stored (w_arr[rs2]),
    .i_we     (reg_write),
    .i_wa     (rd),
    .i_wd     (wd),
    .o_data   (rd2)
  );

  // Debug port reads storage directly and never forwards.
  assign dbg_data = w_arr[dbg_addr];

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: array reference model, directed cases plus random traffic.
module tb_reg_file;
  import riscv_pkg::*;

  localparam logic [31:0] SP = 32'h0000_1000;
`ifdef REGFILE_BYPASS_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic     clk = 1'b0;
  logic     rst = 1'b0;
  logic     reg_write = 1'b0;
  reg_idx_t rd = '0, rs1 = '0, rs2 = '0, dbg_addr = '0;
  xlen_t    wd = '0;
  xlen_t    rd1, rd2, dbg_data;

  logic [31:0] model [32];

  typedef struct {
    string       name;
    int          port;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  event sample_ev;
  int   checks = 0;
  int   errors = 0;

  reg_file #(.DATA_W(32), .ADDR_W(5), .SP_RESET(SP)) dut (
    .clk      (clk),
    .rst      (rst),
    .reg_write(reg_write),
    .rd       (rd),
    .wd       (wd),
    .rs1      (rs1),
    .rs2      (rs2),
    .rd1      (rd1),
    .rd2      (rd2),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] expect_read(int a, bit allow_fwd);
    if (a == 0) return 32'h0;
    if (allow_fwd && FWD && !rst && reg_write && int'(rd) == a) return wd;
    return model[a];
  endfunction

  task automatic check_all(string tag);
    #1;
    sb.push_back('{{tag, ".rd1"}, 0, expect_read(int'(rs1), 1'b1)});
    sb.push_back('{{tag, ".rd2"}, 1, expect_read(int'(rs2), 1'b1)});
    sb.push_back('{{tag, ".dbg"}, 2, expect_read(int'(dbg_addr), 1'b0)});
    ->sample_ev;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    model[2] = SP;
  endtask

  task automatic step(bit we, int a, logic [31:0] d, int r1, int r2, int dbg, string tag);
    @(negedge clk);
    reg_write = we;
    rd        = reg_idx_t'(a);
    wd        = d;
    rs1       = reg_idx_t'(r1);
    rs2       = reg_idx_t'(r2);
    dbg_addr  = reg_idx_t'(dbg);
    check_all({tag, ".pre"});
    @(posedge clk);
    if (!rst && we && a != 0) model[a] = d;
    #1;
    reg_write = 1'b0;
    check_all({tag, ".post"});
  endtask

  // Monitor: pops expectations and compares against the live outputs.
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(sample_ev);
      while (sb.size() != 0) begin
        e   = sb.pop_front();
        act = (e.port == 0) ? rd1 : (e.port == 1) ? rd2 : dbg_data;
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s rs1=%0d rs2=%0d dbg=%0d got=%h expected=%h",
                   e.name, rs1, rs2, dbg_addr, act, e.exp);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    #2;
    do_reset();
    for (int i = 0; i < 32; i++) begin
      dbg_addr = reg_idx_t'(i);
      rs1      = reg_idx_t'(i);
      rs2      = reg_idx_t'(31 - i);
      check_all("reset_sweep");
    end
    @(negedge clk);
    rst = 1'b0;

    step(1'b1, 5, 32'hDEAD_BEEF, 5, 5, 5, "wr_x5");
    step(1'b0, 0, 32'h0, 4, 6, 5, "x4_x6");
    step(1'b1, 0, 32'hFFFF_FFFF, 0, 0, 0, "wr_x0");
    step(1'b1, 7, 32'h0000_0011, 7, 2, 7, "wr_x7");
    step(1'b1, 7, 32'h1234_5678, 7, 7, 7, "hazard_x7");

    step(1'b1, 3, 32'hA5A5_A5A5, 3, 3, 3, "wr_x3");
    @(negedge clk);
    reg_write = 1'b1;
    rd        = reg_idx_t'(3);
    wd        = 32'h5555_5555;
    #2;
    do_reset();
    check_all("midop_rst");
    step(1'b1, 3, 32'h0000_0001, 3, 2, 3, "wr_in_rst");
    @(negedge clk);
    rst = 1'b0;
    check_all("after_rst");

    for (int i = 1; i < 32; i++)
      step(1'b1, i, i * 32'h0101_0101, 0, 0, i, "fill");
    for (int i = 1; i < 32; i++)
      step(1'b0, 0, 32'h0, i, 32 - i, i, "readback");

    for (int n = 0; n < 300; n++) begin
      int a;
      a = $urandom_range(0, 31);
      if ($urandom_range(0, 39) == 0) begin
        @(negedge clk);
        #2;
        do_reset();
        check_all("rnd_rst");
        rst = 1'b0;
      end
      step(1'($urandom_range(0, 1)), a, $urandom,
           ($urandom_range(0, 2) == 0) ? a : $urandom_range(0, 31),
           ($urandom_range(0, 2) == 0) ? a : $urandom_range(0, 31),
           $urandom_range(0, 31), "random");
    end

    #2;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain left=%0d expected=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Architectural integer register file for the single-cycle RV32I core.
- The write-back select mux drives this block's write port.
- Its two read ports feed the ALU-operand and store-data muxes, so it is both the consumer of the write-back mux and the source for the operand muxes.
- One write per clock; reads are combinational within the same cycle. x0 is hardwired to zero.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register index width; number of registers is 2**ADDR_W
- SP_RESET, 32'h0000_0000, reset value of x2 (stack pointer); all other registers reset to 0

Ports:
- clk  input  1  single clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- reg_write  input  1  write enable for the current cycle
- rd  input  ADDR_W  destination register index
- wd  input  DATA_W  write data, from the write-back mux output
- rs1  input  ADDR_W  read port 1 index
- rs2  input  ADDR_W  read port 2 index
- rd1  output  DATA_W  read port 1 data
- rd2  output  DATA_W  read port 2 data
- dbg_addr  input  ADDR_W  debug/bench read index
- dbg_data  output  DATA_W  debug read data

Behaviour:
- Reset:
  - One clock (clk); reset rst is asynchronous and active-high.
  - On rst rising, all registers clear to 0 immediately, without waiting for clk; x2 loads SP_RESET.
  - While rst is high, writes are ignored and register contents hold their reset values.
  - rd1, rd2 and dbg_data reflect the reset contents combinationally, so x2 reads SP_RESET and all others read 0.
- Write:
  - On a clk rising edge with rst=0, reg_write=1 and rd!=0, the array entry at rd takes wd.
  - Latency is one edge: the new value is readable after that edge.
  - rd=0 with reg_write=1 is a silent no-op; no storage changes.
- Read:
  - rdN is a purely combinational function of rsN and the array contents, with zero cycles of latency.
  - rsN=0 always yields 0, regardless of any write attempt.
  - dbg_data follows the same rules as rd1/rd2 (index 0 reads 0). It never bypasses, even when REGFILE_BYPASS_EN is defined.
- Same-cycle read/write hazard: rsN==rd with reg_write=1 in the same cycle.
  - Baseline: rdN returns the old value until the edge, then the new one.
  - The single-cycle core requires no bypass, since the write commits at the end of the instruction.
- Reset mid-operation: if rst asserts during a cycle with reg_write=1, the write is lost and the register shows its reset value.
- Width: no arithmetic. rd/rs indices are full ADDR_W bits and every index is valid, so there is no out-of-range case.
- There is no state machine. Storage is 2**ADDR_W−1 physical registers; x0 is not stored.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding is enabled.
  - When reg_write=1, rd!=0 and rsN==rd, rdN returns wd combinationally in the same cycle.
  - This supports later pipelining of the core.
- Undefined: no forwarding; rdN returns the stored value, as in the baseline.
- In both cases rsN=0 returns 0, and forwarding is suppressed while rst=1.

Decomposition:
- Shared package riscv_pkg holds:
  - XLEN=32 and REG_ADDR_W=5
  - register index constants REG_ZERO=0 and REG_SP=2
  - type reg_idx_t, a REG_ADDR_W-bit vector
  - type xlen_t, an XLEN-bit vector
- One sub-module, rf_read_port, instantiated twice (rd1, rd2). It handles:
  - zero-index masking
  - the optional bypass compare and forward mux
- Storage and write logic stay in reg_file.

Test Plan:
- Reset with SP_RESET=32'h0000_1000: assert rst, then read all 32 indices via dbg_addr → x2=32'h0000_1000, all others 0, with no clk edge needed.
- Write x5=32'hDEAD_BEEF (reg_write=1, rd=5), then one edge with rs1=5, rs2=5 → rd1=rd2=32'hDEAD_BEEF; x4 and x6 unchanged at 0.
- Write x0=32'hFFFF_FFFF → rs1=0 gives 0 before and after the edge; dbg_addr=0 gives 0.
- Same cycle: rd=7, wd=32'h1234_5678, rs1=7, with x7 previously 32'h11 →
  - before the edge, rd1=32'h11 without the macro and 32'h1234_5678 with REGFILE_BYPASS_EN
  - after the edge, rd1=32'h1234_5678 in both builds
- Mid-operation reset: x3=32'hA5A5_A5A5, then assert rst asynchronously between edges → x3 reads 0 at once. A write to x3=32'h1 with rst held high is ignored, and x3 stays 0 after rst drops.
- Write all indices 1..31 with value = index×32'h0101_0101, then read back via rs1, rs2 and dbg → each entry matches exactly; index 31 is correct, with no aliasing to index 0.
